// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings and FIFO entry layout for the configurable UART receiver.
package uart_pkg;
    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    typedef struct packed {
        logic       brk;
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through synchronous FIFO; head reads 0 while empty.
module uart_rx_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_level;
    logic          w_push, w_pop;

    assign empty  = r_level == '0;
    assign full   = r_level == (AW+1)'(DEPTH);
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    assign dout   = empty ? '0 : r_mem[r_rd];
    assign level  = r_level;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with per-frame latched config, 3-sample vote,
// parity/framing/break flags and a FWFT receive FIFO with sticky overrun.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DIV_W      = 12,
    parameter int OSR        = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    input  logic [DIV_W-1:0]              cfg_div,
    input  logic [1:0]                    cfg_bits,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    output logic [7:0]                    m_data,
    output logic                          m_perr,
    output logic                          m_ferr,
    output logic                          m_brk,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          ovr,
    input  logic                          ovr_clr,
    output logic                          rx_active,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PW = $clog2(OSR);

    state_t           r_state, w_next;
    logic [1:0]       r_sync, r_smp, r_cfg_bits, r_cfg_par;
    logic             r_rx_prev, r_cfg_stop2, r_par, r_perr, r_ferr, r_allz, r_ovr;
    logic [DIV_W-1:0] r_div, r_cfg_div;
    logic [PW-1:0]    r_phase;
    logic [7:0]       r_data;
    logic [2:0]       r_cnt;
    logic             w_rx_s, w_start, w_tick, w_s0, w_s1, w_vote_t, w_vote;
    logic             w_par_en, w_last_data, w_push, w_brk, w_full, w_empty, w_pop;
    entry_t           w_word, w_head;

    assign w_rx_s      = r_sync[1];
    assign w_start     = r_state == IDLE && r_rx_prev && !w_rx_s;
    assign w_tick      = r_state != IDLE && r_div == r_cfg_div;
    // Samples land on the ticks that move phase to OSR/2-1, OSR/2 and OSR/2+1.
    assign w_s0        = w_tick && r_phase == PW'(OSR/2-2);
    assign w_s1        = w_tick && r_phase == PW'(OSR/2-1);
    assign w_vote_t    = w_tick && r_phase == PW'(OSR/2);
    assign w_vote      = (r_smp[0] & r_smp[1]) | (r_smp[0] & w_rx_s) | (r_smp[1] & w_rx_s);
    assign w_par_en    = r_cfg_par != PAR_NONE && r_cfg_par != 2'd3;
    assign w_last_data = r_cnt == 3'(r_cfg_bits) + 3'd4;
    assign w_pop       = m_valid && m_ready;
    assign w_word      = '{brk: w_brk, ferr: r_ferr | ~w_vote, perr: r_perr, data: r_data};

    always_comb begin
        w_next = r_state;
        w_push = 1'b0;
        w_brk  = r_allz;
        if (w_start) w_next = START;
        else if (w_vote_t) begin
            case (r_state)
                START:  w_next = w_vote ? IDLE : DATA;
                DATA:   w_next = !w_last_data ? DATA : w_par_en ? PARITY : STOP1;
                PARITY: w_next = STOP1;
                STOP1: begin
                    w_brk  = r_allz & ~w_vote;
                    w_next = r_cfg_stop2 ? STOP2 : IDLE;
                    w_push = !r_cfg_stop2;
                end
                STOP2: begin
                    w_next = IDLE;
                    w_push = 1'b1;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync      <= 2'b11;
            r_rx_prev   <= 1'b1;
            r_smp       <= '0;
            r_div       <= '0;
            r_phase     <= '0;
            r_cfg_div   <= '0;
            r_cfg_bits  <= '0;
            r_cfg_par   <= '0;
            r_cfg_stop2 <= 1'b0;
            r_data      <= '0;
            r_cnt       <= '0;
            r_par       <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_allz      <= 1'b1;
            r_ovr       <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], rxd};
            r_rx_prev <= w_rx_s;
            r_ovr     <= (w_push && w_full && !w_pop) ? 1'b1 : ovr_clr ? 1'b0 : r_ovr;
            if (w_start) begin
                r_cfg_div   <= cfg_div;
                r_cfg_bits  <= cfg_bits;
                r_cfg_par   <= cfg_parity;
                r_cfg_stop2 <= cfg_stop2;
                r_div       <= '0;
                r_phase     <= '0;
                r_data      <= '0;
                r_cnt       <= '0;
                r_par       <= 1'b0;
                r_perr      <= 1'b0;
                r_ferr      <= 1'b0;
                r_allz      <= 1'b1;
            end else if (r_state != IDLE) begin
                r_div <= w_tick ? '0 : r_div + 1'b1;
                if (w_tick) r_phase <= (r_phase == PW'(OSR-1)) ? '0 : r_phase + 1'b1;
            end
            if (w_s0) r_smp[0] <= w_rx_s;
            if (w_s1) r_smp[1] <= w_rx_s;
            if (w_vote_t) begin
                if (r_state == DATA) begin
                    r_data[r_cnt] <= w_vote;
                    r_cnt         <= r_cnt + 1'b1;
                    r_par         <= r_par ^ w_vote;
                end
                if (r_state == PARITY) r_perr <= r_par ^ w_vote ^ (r_cfg_par == PAR_ODD);
                if (r_state == DATA || r_state == PARITY || r_state == STOP1) r_allz <= r_allz & ~w_vote;
                if (r_state == STOP1) r_ferr <= ~w_vote;
            end
        end
    end

    uart_rx_fifo #(.W(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_word),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

    assign m_valid   = !w_empty;
    assign m_data    = w_head.data;
    assign m_perr    = w_head.perr;
    assign m_ferr    = w_head.ferr;
    assign m_brk     = w_head.brk;
    assign ovr       = r_ovr;
    assign rx_active = r_state != IDLE;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed scenarios for the configurable UART receiver.
module tb_uart_rx_cfg;
    localparam int BIT = 13 * 8;

    logic        clk = 1'b0, rst = 1'b1, rxd = 1'b1;
    logic [11:0] cfg_div = 12'd12;
    logic [1:0]  cfg_bits = 2'd3, cfg_parity = 2'd0;
    logic        cfg_stop2 = 1'b0, m_ready = 1'b0, ovr_clr = 1'b0;
    logic [7:0]  m_data;
    logic        m_perr, m_ferr, m_brk, m_valid, ovr, rx_active;
    logic [3:0]  fifo_level;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    uart_rx_cfg dut (
        .clk(clk), .rst(rst), .rxd(rxd), .cfg_div(cfg_div), .cfg_bits(cfg_bits),
        .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .m_data(m_data), .m_perr(m_perr),
        .m_ferr(m_ferr), .m_brk(m_brk), .m_valid(m_valid), .m_ready(m_ready), .ovr(ovr),
        .ovr_clr(ovr_clr), .rx_active(rx_active), .fifo_level(fifo_level)
    );

    // Head entry packed as {brk, ferr, perr, data} for compact comparisons.
    function automatic logic [10:0] head();
        return {m_brk, m_ferr, m_perr, m_data};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rxd = 1'b1;
        end
    endtask

    // gbit: frame bit index whose middle sample is inverted for 12 cycles (-1 for none).
    task automatic send_frame(input logic [7:0] d, input int nb, input int par, input bit stop2,
                              input bit bad_par, input bit bad_stop2, input int gbit, input int gap);
        logic [11:0] bits;
        int          n;
        logic [7:0]  mask;
        mask = 8'hFF >> (8 - nb);
        bits = '0;
        n = 1;
        for (int i = 0; i < nb; i++) bits[n++] = d[i];
        if (par == 1 || par == 2) bits[n++] = (^(d & mask)) ^ (par == 2) ^ bad_par;
        bits[n++] = 1'b1;
        if (stop2) bits[n++] = !bad_stop2;
        for (int j = 0; j < n; j++)
            for (int c = 0; c < BIT; c++) begin
                @(negedge clk);
                rxd = (j == gbit && c >= 46 && c < 58) ? ~bits[j] : bits[j];
            end
        idle(gap * BIT);
    endtask

    task automatic pop();
        @(negedge clk);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (head() !== 11'h000) begin bad++; $display("FAIL reset_head got=%h exp=%h", head(), 11'h000); end
        total++; if ({m_valid, ovr, rx_active} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {m_valid, ovr, rx_active}); end
        total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_8n1();
        send_frame(8'hA5, 8, 0, 0, 0, 0, -1, 1);
        total++; if (head() !== 11'h0A5) begin bad++; $display("FAIL 8n1_head got=%h exp=%h", head(), 11'h0A5); end
        total++; if (fifo_level !== 4'd1) begin bad++; $display("FAIL 8n1_level got=%0d exp=1", fifo_level); end
        total++; if (rx_active !== 1'b0) begin bad++; $display("FAIL 8n1_active got=%b exp=0", rx_active); end
        pop();
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL 8n1_pop got=%b exp=0", m_valid); end
    endtask

    task automatic test_7e1();
        cfg_bits = 2'd2; cfg_parity = 2'd1;
        send_frame(8'h41, 7, 1, 0, 1, 0, -1, 1);
        total++; if (head() !== 11'h141) begin bad++; $display("FAIL 7e1_head got=%h exp=%h", head(), 11'h141); end
        pop();
        send_frame(8'h41, 7, 1, 0, 0, 0, -1, 1);
        total++; if (head() !== 11'h041) begin bad++; $display("FAIL 7e1_good got=%h exp=%h", head(), 11'h041); end
        pop();
        cfg_parity = 2'd2;
        send_frame(8'h41, 7, 2, 0, 0, 0, -1, 1);
        total++; if (head() !== 11'h041) begin bad++; $display("FAIL 7o1_good got=%h exp=%h", head(), 11'h041); end
        pop();
    endtask

    task automatic test_8n2();
        cfg_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b1;
        send_frame(8'h3C, 8, 0, 1, 0, 1, -1, 1);
        total++; if (head() !== 11'h23C) begin bad++; $display("FAIL 8n2_ferr got=%h exp=%h", head(), 11'h23C); end
        pop();
        send_frame(8'h55, 8, 0, 1, 0, 0, -1, 1);
        total++; if (head() !== 11'h055) begin bad++; $display("FAIL 8n2_next got=%h exp=%h", head(), 11'h055); end
        total++; if (fifo_level !== 4'd1) begin bad++; $display("FAIL 8n2_level got=%0d exp=1", fifo_level); end
        pop();
        cfg_stop2 = 1'b0;
    endtask

    task automatic test_break();
        for (int i = 0; i < 20 * BIT; i++) begin
            @(negedge clk);
            rxd = 1'b0;
        end
        total++; if (fifo_level !== 4'd1) begin bad++; $display("FAIL brk_level got=%0d exp=1", fifo_level); end
        total++; if (head() !== 11'h600) begin bad++; $display("FAIL brk_head got=%h exp=%h", head(), 11'h600); end
        idle(3 * BIT);
        total++; if ({fifo_level, rx_active} !== {4'd1, 1'b0}) begin bad++; $display("FAIL brk_release got=%0d/%b exp=1/0", fifo_level, rx_active); end
        pop();
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            rxd = 1'b0;
        end
        total++; if (rx_active !== 1'b1) begin bad++; $display("FAIL glitch_start got=%b exp=1", rx_active); end
        idle(3 * BIT);
        total++; if ({fifo_level, rx_active} !== {4'd0, 1'b0}) begin bad++; $display("FAIL glitch_drop got=%0d/%b exp=0/0", fifo_level, rx_active); end
        send_frame(8'h5A, 8, 0, 0, 0, 0, 4, 1);
        total++; if (head() !== 11'h05A) begin bad++; $display("FAIL noise_vote got=%h exp=%h", head(), 11'h05A); end
        pop();
    endtask

    task automatic test_back_to_back();
        send_frame(8'h12, 8, 0, 0, 0, 0, -1, 0);
        send_frame(8'h34, 8, 0, 0, 0, 0, -1, 1);
        total++; if ({fifo_level, head()} !== {4'd2, 11'h012}) begin bad++; $display("FAIL b2b_first got=%0d/%h exp=2/012", fifo_level, head()); end
        pop();
        total++; if (head() !== 11'h034) begin bad++; $display("FAIL b2b_second got=%h exp=034", head()); end
        pop();
    endtask

    task automatic test_overrun();
        for (int k = 1; k <= 9; k++) send_frame(8'(k), 8, 0, 0, 0, 0, -1, 1);
        total++; if (fifo_level !== 4'd8) begin bad++; $display("FAIL ovr_level got=%0d exp=8", fifo_level); end
        total++; if (ovr !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", ovr); end
        total++; if (head() !== 11'h001) begin bad++; $display("FAIL ovr_head got=%h exp=001", head()); end
        @(negedge clk); ovr_clr = 1'b1;
        @(negedge clk); ovr_clr = 1'b0;
        total++; if (ovr !== 1'b0) begin bad++; $display("FAIL ovr_clr got=%b exp=0", ovr); end
        for (int i = 0; i < 3 * BIT; i++) begin
            @(negedge clk);
            rxd = 1'b0;
        end
        total++; if (rx_active !== 1'b1) begin bad++; $display("FAIL midrst_active got=%b exp=1", rx_active); end
        @(negedge clk); rst = 1'b1; rxd = 1'b1;
        @(negedge clk); rst = 1'b0;
        total++; if ({m_valid, rx_active, fifo_level} !== 6'd0) begin bad++; $display("FAIL midrst_clear got=%b/%b/%0d exp=0/0/0", m_valid, rx_active, fifo_level); end
        idle(12 * BIT);
        total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL midrst_partial got=%0d exp=0", fifo_level); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7e1();
        test_8n2();
        test_break();
        test_glitch();
        test_back_to_back();
        test_overrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Runtime-configurable, oversampling UART receiver with an integrated receive FIFO. It is the successor to the fixed 8N1 receiver. It supports 5–8 data bits, none/even/odd parity, 1 or 2 stop bits, 3-sample majority voting, break detection and overrun reporting. It sits between the board RX pin and the command/byte consumer, and presents received words on a ready/valid stream.

## Interface
- `DIV_W`, 12, width of the sample-tick divisor.
- `OSR`, 8, sample ticks per bit; even, ≥4. At 12 MHz and 115200 baud, use `cfg_div`=12.
- `FIFO_DEPTH`, 8, number of FIFO entries; power of two, ≥2.
- `clk` in 1: system clock; everything runs on it.
- `rst` in 1: synchronous, active-high reset.
- `rxd` in 1: raw asynchronous RX line.
- `cfg_div` in DIV_W: cycles per sample tick minus 1.
- `cfg_bits` in 2: data bits minus 5 (0=5 … 3=8).
- `cfg_parity` in 2: 0 none, 1 even, 2 odd, 3 none.
- `cfg_stop2` in 1: 1 = two stop bits.
- `m_data` out 8: head word, right-aligned, unused upper bits 0.
- `m_perr`, `m_ferr`, `m_brk` out 1 each: parity, framing and break flags of the head word.
- `m_valid` out 1: FIFO not empty.
- `m_ready` in 1: consumer accepts the head word.
- `ovr` out 1: sticky overrun flag.
- `ovr_clr` in 1: clears `ovr`.
- `rx_active` out 1: a frame is in progress.
- `fifo_level` out clog2(FIFO_DEPTH)+1: number of stored entries.

## Operation
- **Input sync.** `rxd` passes through a 2-FF synchroniser that resets to 1. All logic uses the synchronised signal `rx_s`.
- **Start detection.** A start requires `rx_s` 1→0: high on the previous cycle, low on this one. A held-low line never retriggers.
- **Frame start.** On the start-detect cycle the block:
  - latches `cfg_*` for the whole frame, so mid-frame changes have no effect;
  - clears the divider and the phase counter to 0;
  - sets `rx_active`.
- **Sample tick.** A tick fires when the divider equals the latched `cfg_div`; the divider then reloads to 0. The phase counter (0…OSR-1) advances on each tick and wraps at the end of each bit.
- **Vote.** Each bit is sampled on the ticks that move phase to OSR/2-1, OSR/2 and OSR/2+1. The bit value is the majority of the 3 samples, decided on the third.
- **States.** IDLE → START → DATA → [PARITY] → STOP1 → [STOP2] → IDLE.
  - START: a vote of 1 is a glitch. Return to IDLE with no entry.
  - DATA: shift in LSB first, for `cfg_bits`+5 bits.
  - PARITY: entered only if parity is enabled. `perr` = received parity does not match even/odd over the data bits.
  - STOP1/STOP2: `ferr` = any voted stop bit is 0. STOP2 is entered only if `cfg_stop2`=1.
- **Frame end.** On the vote of the final stop bit, the block pushes {brk, ferr, perr, data} and returns to IDLE (mid-bit, for resync). `rx_active` clears on the same edge.
- **Break.** `brk` = all data bits, parity (if enabled) and the first stop bit are 0. `ferr` is also 1.
- **FIFO.** First-word-fall-through. Pop = `m_valid` && `m_ready`.
  - Push when full with no pop: drop the new word, set `ovr`.
  - Push and pop in the same cycle when full: both happen and `ovr` is unchanged.
  - Push when empty: `m_valid` rises on the next cycle.
- **`ovr_clr`.** Clears `ovr`. If an overrun occurs in the same cycle, set wins.
- **Reset (any time, including mid-frame).** State IDLE, FIFO empty, partial frame discarded, synchroniser = 1.

## Timing
- **Output reset values:** `m_valid`, `m_perr`, `m_ferr`, `m_brk`, `ovr` and `rx_active` = 0; `m_data` = 0; `fifo_level` = 0.
- **Bit period:** (`cfg_div`+1)·OSR cycles.
- **Latency:** the entry is written on the clock edge of the final stop-bit vote tick. `m_valid` and `fifo_level` update from the next cycle.
- **Sync delay:** 2 cycles from `rxd` to `rx_s`.
- **Pop timing:** a pop updates `m_data`/flags to the next entry, or drops `m_valid`, on the following cycle.
- **Back-to-back frames:** a new start edge is accepted the cycle after the return to IDLE, with no dead time.

## Structure
- **Package `uart_pkg`:**
  - parity encodings (PAR_NONE, PAR_EVEN, PAR_ODD);
  - state encoding for IDLE/START/DATA/PARITY/STOP1/STOP2;
  - FIFO entry layout: bits 10 brk, 9 ferr, 8 perr, 7:0 data.
- **Sub-module `uart_rx_fifo`:** parametrised FWFT sync FIFO (width 11, `FIFO_DEPTH`) with push, pop, full, empty and level.

## Test plan
1. **8N1:** `cfg_div`=12, send 0xA5 → one entry: `m_data`=0xA5, all flags 0, `fifo_level`=1, `rx_active` low after the frame.
2. **7E1 bad parity:** 7E1, send 0x41 with the parity bit flipped → `m_data`=0x41, `m_perr`=1, `m_ferr`=0.
3. **8N2 bad second stop:** 8N2, send 0x3C with the second stop bit low → `m_ferr`=1, `m_data`=0x3C; the next valid frame 0x55 is received cleanly.
4. **Break:** hold the line low for 20 bit times → exactly one entry with data=0, `brk`=1, `ferr`=1. No new entry until the line goes high and then falls again.
5. **Glitch and noise:**
   - a low pulse of 2 ticks → no entry, `rx_active` back to 0;
   - a single-tick inverted sample on a data bit → masked by the vote.
6. **Overrun and reset:**
   - `FIFO_DEPTH`=8, `m_ready`=0, send 9 frames 0x01…0x09 → `fifo_level`=8, `ovr`=1, head=0x01;
   - `ovr_clr` → `ovr`=0;
   - assert `rst` mid-frame → FIFO empty and no partial entry.
